// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the front end: data width, NOP encoding, default reset PC
// and word-alignment helper.
package riscv_pkg;
    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch port: req/addr toward memory, gnt/rvalid/rdata back.
// Responses return in request order, at least one cycle after the grant.
interface fetch_stage_if;
    import riscv_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush (flush beats push in the same cycle).
// Latency: pushed word readable on dout the next cycle; no overflow guard, caller owns credit.
// Backpressure: pop on empty is ignored; push+pop together keeps the count unchanged.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push && !flush;
    assign do_pop  = pop && (count_q != '0) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;
endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC, in-order imem requests, buffered words to IF/ID; FETCH_BUBBLE_CNT_EN adds a bubble counter.
// Latency: rvalid in cycle N shows on valid_f/instr_f in cycle N+1 (no bypass).
// Backpressure: stall_f holds the head; requests stop once in-flight + buffered words reach FIFO_DEPTH.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    fetch_stage_if.master   imem,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] pc_plus_4_f,
    output logic [XLEN-1:0] instr_f,
    output logic            valid_f,
    output logic [31:0]     bubble_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] deliver_pc_q, deliver_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   kill_cnt_q, kill_cnt_d;
    logic [CW-1:0]   outstanding_ret;
    logic [CW-1:0]   fifo_count;
    logic [XLEN-1:0] fifo_head;
    logic            fifo_empty;
    logic            credit_ok, grant, kill_hit, push, consume;

    // Any word already requested or buffered consumes one slot of credit.
    assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
    assign imem.req  = !rst && !pc_src_e && credit_ok;
    assign imem.addr = fetch_pc_q;

    assign grant    = imem.req && imem.gnt;
    assign kill_hit = imem.rvalid && (kill_cnt_q != '0);
    assign push     = imem.rvalid && !kill_hit;
    assign consume  = valid_f && !stall_f && !pc_src_e;

    always_comb begin
        outstanding_ret = outstanding_q;
        if (imem.rvalid && (outstanding_q != '0)) outstanding_ret = outstanding_q - CW'(1);

        outstanding_d = outstanding_ret;
        if (grant && (outstanding_ret != CW'(FIFO_DEPTH))) outstanding_d = outstanding_ret + CW'(1);

        kill_cnt_d   = kill_cnt_q;
        fetch_pc_d   = fetch_pc_q;
        deliver_pc_d = deliver_pc_q;
        if (pc_src_e) begin
            // Everything still owed by memory after this cycle belongs to the old path.
            kill_cnt_d   = outstanding_ret;
            fetch_pc_d   = align_word(pc_target_e);
            deliver_pc_d = align_word(pc_target_e);
        end else begin
            if (kill_hit) kill_cnt_d   = kill_cnt_q - CW'(1);
            if (grant)    fetch_pc_d   = fetch_pc_q + 32'd4;
            if (consume)  deliver_pc_d = deliver_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            deliver_pc_q  <= RESET_PC;
            outstanding_q <= '0;
            kill_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            deliver_pc_q  <= deliver_pc_d;
            outstanding_q <= outstanding_d;
            kill_cnt_q    <= kill_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (consume),
        .flush (pc_src_e),
        .din   (imem.rdata),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign valid_f     = !fifo_empty;
    assign instr_f     = fifo_empty ? NOP_INSTR : fifo_head;
    assign pc_f        = deliver_pc_q;
    assign pc_plus_4_f = deliver_pc_q + 32'd4;

`ifdef FETCH_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!valid_f && !stall_f && !pc_src_e) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bubble_cnt_q <= '0;
        else     bubble_cnt_q <= bubble_cnt_d;
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    assign bubble_cnt = 32'd0;
`endif
endmodule
